// File: rtl/sine_pdm_dac_pkg.sv
// Shared constants and the sine table generator for the test-tone DAC path.
// sine_rom() is evaluated at elaboration time to build the ROM contents.
package sine_pdm_pkg;

    localparam int SINE_WIDTH  = 8;
    localparam int PHASE_WIDTH = 8;

    // pi in Q30 fixed point
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(127.5 + 127.5*sin(2*pi*p/256)); quarter-wave folded, Taylor series in Q30
    function automatic logic [SINE_WIDTH-1:0] sine_rom(input int p);
        int     q;
        int     h;
        int     a;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint v;
        q    = p & 255;
        h    = q & 127;
        a    = (h <= 64) ? h : 128 - h;
        x    = (longint'(a) * PI_Q30) >>> 7;
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        if (q >= 128) s = -s;
        v = ((longint'(128) <<< 31) + longint'(255) * s) >>> 31;
        return SINE_WIDTH'(v);
    endfunction

endpackage

// File: rtl/sine_pdm_dac_if.sv
// Control strobes and outputs of the sine PDM DAC, grouped for port connection.
interface sine_pdm_dac_if;
    import sine_pdm_pkg::*;

    logic                  sine_ce;
    logic                  sample_load;
    logic [SINE_WIDTH-1:0] sine_out;
    logic                  dac_out;

    modport master (
        output sine_ce,
        output sample_load,
        input  sine_out,
        input  dac_out
    );

    modport slave (
        input  sine_ce,
        input  sample_load,
        output sine_out,
        output dac_out
    );

endinterface

// File: rtl/sine_pdm_dac_pdm.sv
// First-order pulse-density modulator: the carry out of a free-running
// accumulator is the 1-bit DAC stream.
module pdm_modulator #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] sample,
    output logic                   dac_out
);

    logic [INPUT_WIDTH-1:0] acc_p0;
    logic [INPUT_WIDTH:0]   sum;

    assign sum = {1'b0, acc_p0} + {1'b0, sample};

    // stage p0: accumulator keeps its residue across sample changes
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0  <= '0;
            dac_out <= 1'b0;
        end else begin
            acc_p0  <= sum[INPUT_WIDTH-1:0];
            dac_out <= sum[INPUT_WIDTH];
        end
    end

endmodule

// File: rtl/sine_pdm_dac.sv
// Test-tone DAC path: table sine generator, audio-rate sample-and-hold, and
// a first-order PDM driving a 1-bit output pin.
module sine_pdm_dac
    import sine_pdm_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int PHASE_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    sine_pdm_dac_if.slave  bus
);

    if (INPUT_WIDTH < SINE_WIDTH || PHASE_WIDTH != sine_pdm_pkg::PHASE_WIDTH) begin : g_bad_cfg
        $error("sine_pdm_dac: unsupported INPUT_WIDTH/PHASE_WIDTH");
    end

    logic [SINE_WIDTH-1:0] rom [2**PHASE_WIDTH];

    for (genvar g = 0; g < 2**PHASE_WIDTH; g++) begin : g_rom
        localparam logic [SINE_WIDTH-1:0] ENTRY = sine_rom(g);
        assign rom[g] = ENTRY;
    end

    logic [PHASE_WIDTH-1:0] phase_p0;
    logic [SINE_WIDTH-1:0]  sine_p1;
    logic [INPUT_WIDTH-1:0] sample_p2;

    // stage p0 phase, p1 ROM lookup, p2 hold register (captures p1 before it updates)
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_p0  <= '0;
            sine_p1   <= SINE_WIDTH'(8'h80);
            sample_p2 <= '0;
        end else begin
            if (bus.sine_ce) phase_p0 <= phase_p0 + PHASE_WIDTH'(1);
            sine_p1 <= rom[phase_p0];
            if (bus.sample_load)
                sample_p2 <= INPUT_WIDTH'(sine_p1) << (INPUT_WIDTH - SINE_WIDTH);
        end
    end

    assign bus.sine_out = sine_p1;

    pdm_modulator #(
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_pdm (
        .clk     (clk),
        .reset   (reset),
        .sample  (sample_p2),
        .dac_out (bus.dac_out)
    );

endmodule

// File: tb/tb_sine_pdm_dac.sv
// Directed bench for sine_pdm_dac with a cycle model feeding an expectation queue.
module tb_sine_pdm_dac;
    import sine_pdm_pkg::*;

    localparam int IW = 8;

    typedef struct packed {
        logic [7:0] sine;
        logic       dac;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    sine_pdm_dac_if bus ();

    sine_pdm_dac #(
        .INPUT_WIDTH(IW),
        .PHASE_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]    m_phase;
    logic [7:0]    m_sine;
    logic [IW-1:0] m_sample;
    logic [IW-1:0] m_acc;
    logic          m_dac;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ones   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // advance the model over the coming edge, push its outputs, then compare after the edge
    task automatic tick();
        logic [IW:0] sum;
        exp_t e;
        if (reset) begin
            m_phase  = '0;
            m_sine   = 8'h80;
            m_sample = '0;
            m_acc    = '0;
            m_dac    = 1'b0;
        end else begin
            sum   = {1'b0, m_acc} + {1'b0, m_sample};
            m_dac = sum[IW];
            m_acc = sum[IW-1:0];
            if (bus.sample_load) m_sample = IW'(m_sine) << (IW - 8);
            m_sine = sine_rom(int'(m_phase));
            if (bus.sine_ce) m_phase = m_phase + 8'd1;
        end
        q.push_back('{sine: m_sine, dac: m_dac});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("sine_out", 32'(bus.sine_out), 32'(e.sine));
            check("dac_out", 32'(bus.dac_out), 32'(e.dac));
        end
        if (bus.dac_out === 1'b1) ones++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic step_phase(input int n);
        bus.sine_ce = 1'b1;
        idle(n);
        bus.sine_ce = 1'b0;
        tick();
    endtask

    task automatic load_and_count(input string tag, input int exp_ones);
        bus.sample_load = 1'b1;
        tick();
        bus.sample_load = 1'b0;
        ones = 0;
        idle(256);
        check(tag, 32'(ones), 32'(exp_ones));
    endtask

    initial begin
        int s;
        reset           = 1'b1;
        bus.sine_ce     = 1'b0;
        bus.sample_load = 1'b0;

        // reset, including strobes that must be ignored
        idle(2);
        bus.sine_ce     = 1'b1;
        bus.sample_load = 1'b1;
        tick();
        bus.sine_ce     = 1'b0;
        bus.sample_load = 1'b0;
        check("rst_sine", 32'(bus.sine_out), 32'h80);
        check("rst_dac", 32'(bus.dac_out), 32'd0);
        reset = 1'b0;

        // idle: mid-scale sine, silent output
        ones = 0;
        idle(512);
        check("idle_ones", 32'(ones), 32'd0);
        check("idle_sine", 32'(bus.sine_out), 32'h80);

        // half-scale sample: alternating 0,1 after the load
        load_and_count("half_ones", 128);

        // full sine cycle with 1-in-4 enables
        for (int i = 1; i <= 256; i++) begin
            bus.sine_ce = 1'b1;
            tick();
            bus.sine_ce = 1'b0;
            tick();
            if (i == 64)  check("sine_p64", 32'(bus.sine_out), 32'd255);
            if (i == 128) check("sine_p128", 32'(bus.sine_out), 32'd128);
            if (i == 192) check("sine_p192", 32'(bus.sine_out), 32'd0);
            if (i == 256) check("sine_wrap", 32'(bus.sine_out), 32'd128);
            idle(2);
        end

        // full-scale sample
        step_phase(64);
        check("sine_peak", 32'(bus.sine_out), 32'd255);
        load_and_count("full_ones", 255);

        // a mid-range sample near quarter scale
        step_phase(86);
        s = int'(sine_rom(150));
        load_and_count("q150_ones", s);

        // zero sample
        step_phase(42);
        check("sine_trough", 32'(bus.sine_out), 32'd0);
        load_and_count("zero_ones", 0);

        // load coinciding with a phase step captures the pre-step sine
        step_phase(96);
        s = int'(sine_rom(32));
        bus.sine_ce     = 1'b1;
        bus.sample_load = 1'b1;
        tick();
        bus.sine_ce     = 1'b0;
        bus.sample_load = 1'b0;
        ones = 0;
        idle(256);
        check("coincide_ones", 32'(ones), 32'(s));

        // reset mid-operation
        reset = 1'b1;
        tick();
        check("midrst_sine", 32'(bus.sine_out), 32'h80);
        check("midrst_dac", 32'(bus.dac_out), 32'd0);
        reset = 1'b0;
        ones = 0;
        idle(256);
        check("midrst_ones", 32'(ones), 32'd0);

        // audio-rate operation: enable every 4 clks, load every 1000 clks
        for (int l = 0; l < 20; l++) begin
            bus.sample_load = 1'b1;
            bus.sine_ce     = 1'b1;
            tick();
            bus.sample_load = 1'b0;
            s    = int'(m_sample);
            ones = 0;
            for (int k = 1; k < 1000; k++) begin
                bus.sine_ce = (k % 4 == 0);
                tick();
            end
            bus.sine_ce = 1'b0;
            check_range("load_mean", ones, (s * 999) / 256 - 1, (s * 999) / 256 + 1);
        end

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
